// File: rtl/pc_gen.sv
// pc_gen: IF-stage fetch PC generator.
// Owns the architectural fetch PC and picks the next PC from these sources,
// highest priority first: exception, branch, jump, return, sequential.
// A redirect that arrives during a fetch stall is held in a park register
// until the stall releases.
// Optional return-address stack, enabled by defining PC_GEN_RAS_EN.
module pc_gen #(
  parameter int unsigned      WIDTH        = 32,
  parameter int unsigned      INC          = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_3000,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'h0000_4180,
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             exc_valid,
  input  logic             br_valid,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jmp_valid,
  input  logic [WIDTH-1:0] jmp_target,
  input  logic             ret_valid,
  input  logic [WIDTH-1:0] ret_target,
  input  logic             ras_push,
  input  logic [WIDTH-1:0] push_addr,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic             pc_valid,
  output logic             pending
);

  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  // Request ranks: a larger value wins.
  localparam logic [2:0] PRI_NONE = 3'd0;
  localparam logic [2:0] PRI_RET  = 3'd1;
  localparam logic [2:0] PRI_JMP  = 3'd2;
  localparam logic [2:0] PRI_BR   = 3'd3;
  localparam logic [2:0] PRI_EXC  = 3'd4;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] park_q, park_d;
  logic [2:0]       parkPrio_q, parkPrio_d;

  logic [2:0]       reqPrio;
  logic [WIDTH-1:0] reqTarget;
  logic [WIDTH-1:0] retTarget;

  assign pc       = pc_q;
  assign pc_plus  = pc_q + WIDTH'(INC);
  assign pc_valid = (state_q != BOOT);
  assign pending  = (state_q == HOLD);

`ifdef PC_GEN_RAS_EN
  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);

  logic [WIDTH-1:0] rasMem_q [RAS_DEPTH];
  logic [PTR_W-1:0] rasPtr_q, rasPtr_d;
  logic [PTR_W:0]   rasCount_q, rasCount_d;
  logic [PTR_W-1:0] topIdx;
  logic             rasActive;
  logic             doPush;
  logic             doPop;

  // rasPtr_q is the next free slot; the newest entry sits just below it.
  assign topIdx    = rasPtr_q - PTR_W'(1);
  assign rasActive = (state_q != BOOT);
  assign doPush    = ras_push && rasActive;
  assign doPop     = ret_valid && rasActive && (rasCount_q != '0);
  assign retTarget = (rasCount_q != '0) ? rasMem_q[topIdx] : ret_target;

  // Stack pointer/count update; a push and a pop together leave both unchanged.
  always_comb begin
    rasPtr_d   = rasPtr_q;
    rasCount_d = rasCount_q;
    if (doPush && !doPop) begin
      rasPtr_d = rasPtr_q + PTR_W'(1);
      if (rasCount_q != (PTR_W+1)'(RAS_DEPTH)) begin
        rasCount_d = rasCount_q + (PTR_W+1)'(1);
      end
    end else if (doPop && !doPush) begin
      rasPtr_d   = rasPtr_q - PTR_W'(1);
      rasCount_d = rasCount_q - (PTR_W+1)'(1);
    end
  end

  // Stack storage; a push with a pop replaces the top, otherwise it writes the free slot.
  always_ff @(posedge clk) begin
    if (doPush) begin
      rasMem_q[doPop ? topIdx : rasPtr_q] <= push_addr;
    end
  end

  // Stack bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rasPtr_q   <= '0;
      rasCount_q <= '0;
    end else begin
      rasPtr_q   <= rasPtr_d;
      rasCount_q <= rasCount_d;
    end
  end
`else
  localparam int unsigned unusedRasDepth = RAS_DEPTH;
  logic unusedRas;

  assign unusedRas = ras_push ^ (^push_addr);
  assign retTarget = ret_target;
`endif

  // Pick the highest-priority redirect requested this cycle.
  always_comb begin
    reqPrio   = PRI_NONE;
    reqTarget = pc_plus;
    if (exc_valid) begin
      reqPrio   = PRI_EXC;
      reqTarget = EXC_VECTOR;
    end else if (br_valid) begin
      reqPrio   = PRI_BR;
      reqTarget = br_target;
    end else if (jmp_valid) begin
      reqPrio   = PRI_JMP;
      reqTarget = jmp_target;
    end else if (ret_valid) begin
      reqPrio   = PRI_RET;
      reqTarget = retTarget;
    end
  end

  // Next-state logic for the PC, park register and BOOT/RUN/HOLD sequencing.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    park_d     = park_q;
    parkPrio_d = parkPrio_q;
    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (!stall) begin
          pc_d = reqTarget;
        end else if (reqPrio != PRI_NONE) begin
          park_d     = reqTarget;
          parkPrio_d = reqPrio;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (stall) begin
          if (reqPrio > parkPrio_q) begin
            park_d     = reqTarget;
            parkPrio_d = reqPrio;
          end
        end else begin
          pc_d       = (reqPrio > parkPrio_q) ? reqTarget : park_q;
          parkPrio_d = PRI_NONE;
          state_d    = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // Architectural PC, FSM state and park register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      park_q     <= '0;
      parkPrio_q <= PRI_NONE;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      park_q     <= park_d;
      parkPrio_q <= parkPrio_d;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: randomized and directed checks of pc_gen against a behavioural model.
// Return-stack tests are compiled in when PC_GEN_RAS_EN is defined.
module tb_pc_gen;

  localparam logic [31:0] RESET_VEC = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC   = 32'h0000_4180;
  localparam int          DEPTH     = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, exc_valid, br_valid, jmp_valid, ret_valid, ras_push;
  logic [31:0] br_target, jmp_target, ret_target, push_addr;
  logic [31:0] pc, pc_plus;
  logic        pc_valid, pending;

  int assertCount = 0;
  int failCount   = 0;

  // Behavioural model state.
  logic [31:0] mPc;
  bit          mBoot;
  bit          mHold;
  logic [31:0] mParkTarget;
  int          mParkRank;
  logic [31:0] mStack[$];

  pc_gen dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .exc_valid(exc_valid),
    .br_valid(br_valid), .br_target(br_target),
    .jmp_valid(jmp_valid), .jmp_target(jmp_target),
    .ret_valid(ret_valid), .ret_target(ret_target),
    .ras_push(ras_push), .push_addr(push_addr),
    .pc(pc), .pc_plus(pc_plus), .pc_valid(pc_valid), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".pc"}, pc, mPc);
    checkOutput({tag, ".pc_plus"}, pc_plus, mPc + 32'd4);
    checkOutput({tag, ".pc_valid"}, {31'd0, pc_valid}, {31'd0, !mBoot});
    checkOutput({tag, ".pending"}, {31'd0, pending}, {31'd0, mHold});
  endtask

  task automatic modelReset();
    mPc = RESET_VEC;
    mBoot = 1'b1;
    mHold = 1'b0;
    mParkTarget = '0;
    mParkRank = 0;
    mStack.delete();
  endtask

  // Advance the model by one edge using the current input values.
  task automatic modelEdge();
    int          rank;
    logic [31:0] tgt;
    logic [31:0] retT;
    if (mBoot) begin
      mBoot = 1'b0;
      return;
    end
    retT = ret_target;
`ifdef PC_GEN_RAS_EN
    if (mStack.size() > 0) retT = mStack[$];
`endif
    rank = 0;
    tgt  = mPc + 32'd4;
    if (exc_valid)      begin rank = 4; tgt = EXC_VEC;    end
    else if (br_valid)  begin rank = 3; tgt = br_target;  end
    else if (jmp_valid) begin rank = 2; tgt = jmp_target; end
    else if (ret_valid) begin rank = 1; tgt = retT;       end
    if (!mHold) begin
      if (!stall) mPc = tgt;
      else if (rank > 0) begin
        mHold = 1'b1;
        mParkTarget = tgt;
        mParkRank = rank;
      end
    end else if (stall) begin
      if (rank > mParkRank) begin
        mParkTarget = tgt;
        mParkRank = rank;
      end
    end else begin
      mPc = (rank > mParkRank) ? tgt : mParkTarget;
      mHold = 1'b0;
      mParkRank = 0;
    end
`ifdef PC_GEN_RAS_EN
    if (ret_valid && mStack.size() > 0) void'(mStack.pop_back());
    if (ras_push) begin
      mStack.push_back(push_addr);
      if (mStack.size() > DEPTH) void'(mStack.pop_front());
    end
`endif
  endtask

  // Drive one cycle of inputs, clock it, update the model and compare.
  task automatic applyStimulus(input string tag, input logic st, input logic ex,
                               input logic br, input logic [31:0] bt,
                               input logic jm, input logic [31:0] jt,
                               input logic rt, input logic [31:0] rtt,
                               input logic ps, input logic [31:0] pa);
    stall = st; exc_valid = ex;
    br_valid = br; br_target = bt;
    jmp_valid = jm; jmp_target = jt;
    ret_valid = rt; ret_target = rtt;
    ras_push = ps; push_addr = pa;
    @(posedge clk);
    modelEdge();
    #1;
    checkAll(tag);
  endtask

  task automatic idle(input string tag);
    applyStimulus(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    stall = 0; exc_valid = 0; br_valid = 0; jmp_valid = 0; ret_valid = 0; ras_push = 0;
    br_target = 0; jmp_target = 0; ret_target = 0; push_addr = 0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkAll("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    doReset();

    // Boot cycle, then sequential fetch.
    idle("boot");
    checkOutput("bootPc", pc, 32'h3000);
    checkOutput("bootValid", {31'd0, pc_valid}, 32'd1);
    idle("seq1");
    checkOutput("seq1Pc", pc, 32'h3004);
    idle("seq2");
    checkOutput("seq2Pc", pc, 32'h3008);

    // Wrap at the top of the address space.
    applyStimulus("jmpTop", 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
    checkOutput("topPc", pc, 32'hFFFF_FFFC);
    idle("wrap");
    checkOutput("wrapPc", pc, 32'h0);
    checkOutput("wrapPlus", pc_plus, 32'h4);

    // Exception beats branch and jump.
    applyStimulus("excWins", 0, 1, 1, 32'h3100, 1, 32'h3500, 0, 0, 0, 0);
    checkOutput("excPc", pc, 32'h4180);

    // Stalled branch is parked; lower-priority jump is dropped.
    applyStimulus("hold1", 1, 0, 1, 32'h3200, 0, 0, 0, 0, 0, 0);
    applyStimulus("hold2", 1, 0, 0, 0, 1, 32'h3300, 0, 0, 0, 0);
    checkOutput("hold2Pend", {31'd0, pending}, 32'd1);
    applyStimulus("hold3", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("release", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("releasePc", pc, 32'h3200);
    checkOutput("releasePend", {31'd0, pending}, 32'd0);

    // Exception while parked overrides on release.
    applyStimulus("park4", 1, 0, 0, 0, 1, 32'h3600, 0, 0, 0, 0);
    applyStimulus("excRel", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("excRelPc", pc, 32'h4180);

    // Reset in HOLD discards the parked redirect.
    applyStimulus("park5", 1, 0, 1, 32'h3700, 0, 0, 0, 0, 0, 0);
    checkOutput("park5Pend", {31'd0, pending}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("asyncRstPc", pc, 32'h3000);
    checkOutput("asyncRstPend", {31'd0, pending}, 32'd0);
    doReset();
    idle("boot2");

`ifdef PC_GEN_RAS_EN
    // Push five into a four-deep stack, then pop past empty.
    for (int i = 1; i <= 5; i++) applyStimulus("push", 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'(i * 16));
    for (int i = 0; i < 5; i++) begin
      logic [31:0] expRet;
      expRet = (i < 4) ? 32'(80 - 16 * i) : 32'h99;
      applyStimulus("ret", 0, 0, 0, 0, 0, 0, 1, 32'h99, 0, 0);
      checkOutput("rasPop", pc, expRet);
    end
    applyStimulus("push10", 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h10);
    applyStimulus("retPush", 0, 0, 0, 0, 0, 0, 1, 32'h99, 1, 32'h60);
    checkOutput("retPushPc", pc, 32'h10);
    applyStimulus("retAfter", 0, 0, 0, 0, 0, 0, 1, 32'h99, 0, 0);
    checkOutput("retAfterPc", pc, 32'h60);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus("rand",
                    ($urandom_range(0, 9) < 4),
                    ($urandom_range(0, 19) == 0),
                    ($urandom_range(0, 4) == 0), $urandom,
                    ($urandom_range(0, 4) == 0), $urandom,
                    ($urandom_range(0, 4) == 0), $urandom,
                    ($urandom_range(0, 4) == 0), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised successor to the fixed PC+4 incrementer: owns the architectural fetch PC register, not just the adder.
- Selects next PC from sequential, branch, jump, return and exception sources by fixed priority.
- Handles fetch stalls by parking redirects that arrive while stalled.
- Sits at the IF stage and drives the instruction-memory address and the IF/ID pc_plus value.

Parameters:
WIDTH, 32, PC and target width in bits
INC, 4, sequential increment (bytes per instruction)
RESET_VECTOR, 32'h0000_3000, PC loaded on reset
EXC_VECTOR, 32'h0000_4180, PC loaded on exception redirect
RAS_DEPTH, 4, return-address-stack entries (power of 2, ≥2; used only with RAS_EN)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  hold PC (hazard unit)
exc_valid  in  1  exception redirect to EXC_VECTOR
br_valid  in  1  taken branch
br_target  in  WIDTH  branch target
jmp_valid  in  1  jump (j/jal)
jmp_target  in  WIDTH  jump target
ret_valid  in  1  return (jr $ra)
ret_target  in  WIDTH  register-read return address
ras_push  in  1  call seen (jal), push push_addr
push_addr  in  WIDTH  return address to push
pc  out  WIDTH  current fetch PC
pc_plus  out  WIDTH  pc + INC, modulo 2^WIDTH
pc_valid  out  1  fetch at pc is valid this cycle
pending  out  1  parked redirect waiting for stall release

Behaviour:
- Reset (rst_n=0, async): pc=RESET_VECTOR, pc_valid=0, pending=0, state=BOOT, RAS count=0, RAS pointer=0.
- pc_plus is combinational from pc and wraps: 32'hFFFF_FFFC+4 → 0.
- Request priority: exc > br > jmp > ret > sequential.
- States:
  - BOOT: first edge after reset release → RUN, pc_valid=1, pc unchanged. All requests are ignored in BOOT.
  - RUN, stall=0: pc ← winning target, else pc_plus; pc_valid=1.
  - RUN, stall=1 with any request: latch winning target into the park register, pending=1, go to HOLD. pc holds.
  - RUN, stall=1, no request: pc holds, stay in RUN.
  - HOLD, stall=1: pc holds. A new request overwrites the park register only if its priority is strictly higher than the parked one; equal or lower priority is dropped.
  - HOLD, stall=0: merge parked and new request by priority; on a tie the parked one wins. pc ← winner, pending=0, → RUN.
- Exception always overrides, including in HOLD with stall=0.
- Latency: redirect is visible on pc one cycle after the request edge, when not stalled.
- Targets are used as given (no alignment check, no masking).
- Reset mid-HOLD discards the parked redirect.

Optional Feature:
- Macro: PC_GEN_RAS_EN.
- Defined:
  - RAS_DEPTH-entry circular stack; ras_push pushes push_addr.
  - ret_valid uses the stack top as target and pops; ret_target is ignored while count>0.
  - Pop on empty falls back to ret_target; count stays 0.
  - Push when full overwrites the oldest entry; count saturates at RAS_DEPTH.
  - Same-cycle push+pop: return target is the old top, then push_addr replaces it (count unchanged).
  - Push/pop are not gated by stall; a pop while stalled parks the popped value.
- Undefined: no stack logic; ras_push and push_addr are ignored; ret uses ret_target.

Test Plan:
- Reset release → pc=32'h3000, pc_valid=0 for 1 cycle, then 3000,3004,3008 on successive edges; pc_plus=pc+4.
- pc forced via sequence near top: pc=32'hFFFF_FFFC, no stall → next pc=0, pc_plus then=4.
- Same-cycle exc_valid, br_valid (0x3100) and jmp_valid → pc=32'h4180 next cycle.
- stall=1; br_valid (0x3200) in cycle 1; jmp_valid (0x3300) in cycle 2; stall drops in cycle 4 → pending=1 cycles 2–4, pc=0x3200 after release, jmp dropped; rst_n low mid-HOLD → pc=0x3000, pending=0.
- RAS_EN, depth 4: push 0x10,0x20,0x30,0x40,0x50, then five rets with ret_target=0x99 → targets 0x50,0x40,0x30,0x20, then 0x99 on empty.
- RAS_EN: push 0x10; same-cycle ret_valid+ras_push(0x60) → pc=0x10; next ret → pc=0x60.
